demux_dispatch4: RTL
====================

Name: demux_dispatch4

Overview:
Registered 1-to-4 distributor, the inverse of the datapath source-select muxes: one producer stream is routed to one of four consumer ports by a one-hot destination select. A two-entry skid buffer gives full throughput with valid/ready handshakes on both sides. Sits between a shared result bus and the per-destination units (register file write port, MAR/MDR loaders, I/O). Illegal selects are dropped, counted and flagged.

Parameters:
N, 16, data width in bits
CNT_W, 8, width of the saturating drop counter

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
In_Valid  input  1  producer has a word
In_Ready  output  1  block can accept a word this cycle
In_Data  input  N  word to route
In_Sel  input  4  one-hot destination: bit0=port A, bit1=B, bit2=C, bit3=D
Out_Data  output  N  head word, fanned out to all four ports
Out_Valid  output  4  one-hot; bit k high = head word targets port k
Out_Ready  input  4  per-port consumer ready
Err_Sticky  output  1  set on any illegal select
Drop_Count  output  CNT_W  number of dropped words, saturating
Clear_Err  input  1  synchronous clear of Err_Sticky and Drop_Count

Behaviour:
- Reset (Reset_n low, asynchronous): state EMPTY; Out_Valid=4'b0000; Out_Data=0; skid entry=0; Err_Sticky=0; Drop_Count=0. In_Ready=1 after reset is released.
- Push = In_Valid & In_Ready. Pop = |(Out_Valid & Out_Ready). Ready on a non-selected port has no effect.
- Legal select = exactly one bit of In_Sel set. Push with illegal select (0000 or ≥2 bits): word discarded, no state/buffer change, Err_Sticky<=1, Drop_Count+1 (holds at all-ones). Clear_Err has priority over a same-cycle drop: both cleared, drop not counted.
- Legal push: Out_Valid/Out_Data take word at next edge (latency 1 cycle).
- In_Ready = (state != TWO), purely a function of registered state; no combinational path from Out_Ready.
- States (head = Out_Data/Out_Valid register, skid = second entry):
  EMPTY: legal push -> ONE (head<=word).
  ONE: push&pop -> ONE (head<=new word); push only -> TWO (skid<=word); pop only -> EMPTY (Out_Valid<=0); neither -> ONE.
  TWO: In_Ready=0; pop -> ONE (head<=skid); else hold.
- Illegal push counts as "no push" in the above transitions (pop still applies).
- Order preserved: words leave in acceptance order regardless of destination; a stalled port blocks following words (head-of-line blocking is intended).
- Out_Data/Out_Valid stable while Out_Valid nonzero and not popped.
- Reset mid-transfer: buffered words lost; counters cleared.

Decomposition:
- Package dispatch_pkg: state enum {EMPTY, ONE, TWO}; port index constants PORT_A..PORT_D; function is_onehot4().
- One sub-module: dispatch_skid_buf (two-entry buffer of {sel, data} with valid/ready); top adds select check, error counter and output decode.

Test Plan:
- Reset then In_Sel=0010, In_Data=16'h1234, Out_Ready=1111 -> next cycle Out_Valid=0010, Out_Data=16'h1234; popped same cycle, EMPTY after.
- Back-to-back 8 words to ports A,B,C,D,A,B,C,D with Out_Ready=1111 -> one word out per cycle, order and one-hot Out_Valid match, In_Ready never low.
- Out_Ready=0000, push 16'hAAAA->C then 16'hBBBB->D -> In_Ready=0 after second; third word held off; raise Out_Ready[2] -> AAAA pops, BBBB becomes head, In_Ready=1 next cycle.
- Head targets port B, Out_Ready=1101 -> word held indefinitely, no pop; Out_Ready[1]=1 -> pops.
- In_Sel=0000 then 0110, In_Data arbitrary -> no Out_Valid, Err_Sticky=1, Drop_Count=2; 300 illegal pushes -> Drop_Count=8'hFF; Clear_Err -> both 0.
- Reset_n low with state TWO -> Out_Valid=0000 immediately (async), In_Ready=1 after release, first new word emerges 1 cycle after push.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the 1-to-4 result dispatcher.
// Holds the buffer state encoding, the port indices and the select check.
package dispatch_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;
    localparam int PORT_C = 2;
    localparam int PORT_D = 3;

    // A non-zero value with its lowest set bit cleared is zero only when one bit was set.
    function automatic logic is_onehot4(input logic [3:0] sel);
        return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/dispatch_skid_buf.sv
// Two-entry buffer. The head register drives the outputs directly, and the skid entry absorbs one word.
// ready depends only on registered state, so there is no path from the consumer side to the producer side.
module dispatch_skid_buf
    import dispatch_pkg::*;
#(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         head_valid,
    output logic         ready
);

    state_t       state, state_nxt;
    logic [W-1:0] head, skid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        head_valid = (state != EMPTY);
        ready      = (state != TWO);
    end

    // When the buffer is drained, head keeps its stale word; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            case (state)
                EMPTY: if (push) head <= din;
                ONE: begin
                    if (push && pop) head <= din;
                    else if (push)   skid <= din;
                end
                TWO:     if (pop) head <= skid;
                default: ;
            endcase
        end
    end

    assign dout = head;

endmodule

// File: rtl/demux_dispatch4.sv
// Registered 1-to-4 distributor. A word is routed by a one-hot select through a two-entry buffer.
// Illegal selects are dropped, counted (saturating) and flagged in a sticky error bit.
module demux_dispatch4
    import dispatch_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [N-1:0]     In_Data,
    input  logic [3:0]       In_Sel,
    output logic [N-1:0]     Out_Data,
    output logic [3:0]       Out_Valid,
    input  logic [3:0]       Out_Ready,
    output logic             Err_Sticky,
    output logic [CNT_W-1:0] Drop_Count,
    input  logic             Clear_Err
);

    logic         legal, push, drop, pop, head_valid;
    logic [N+3:0] head;

    assign legal = is_onehot4(In_Sel);
    assign push  = In_Valid && In_Ready && legal;
    assign drop  = In_Valid && In_Ready && !legal;
    assign pop   = |(Out_Valid & Out_Ready);

    dispatch_skid_buf #(.W(N + 4)) u_buf (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .push       (push),
        .pop        (pop),
        .din        ({In_Sel, In_Data}),
        .dout       (head),
        .head_valid (head_valid),
        .ready      (In_Ready)
    );

    assign Out_Data  = head[N-1:0];
    assign Out_Valid = head_valid ? head[N+3:N] : 4'b0000;

    // When a clear and a drop arrive in the same cycle, the clear wins and the drop is not counted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Err_Sticky <= 1'b0;
            Drop_Count <= '0;
        end else if (Clear_Err) begin
            Err_Sticky <= 1'b0;
            Drop_Count <= '0;
        end else if (drop) begin
            Err_Sticky <= 1'b1;
            if (Drop_Count != {CNT_W{1'b1}}) Drop_Count <= Drop_Count + CNT_W'(1);
        end
    end

endmodule
